// File: rtl/dbg_port_master.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : dbg_port_master                                              |
// | Description : Byte-stream debug port: halts/steps the CPU, reads RF/DM/IM, |
// |               writes DM/IM. Optional macro DBG_RX_TIMEOUT_EN enables an     |
// |               inter-byte receive timeout.                                  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module dbg_port_master (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        debug,
  output logic        clk_cpu,
  output logic [31:0] addr,
  output logic [31:0] din,
  output logic        we_dm,
  output logic        we_im,
  output logic        clk_ld,
  input  logic [31:0] dout_rf,
  input  logic [31:0] dout_dm,
  input  logic [31:0] dout_im,
  input  logic [31:0] pc
);

  localparam logic [7:0] c_OP_RD_RF  = 8'h01;
  localparam logic [7:0] c_OP_RD_DM  = 8'h02;
  localparam logic [7:0] c_OP_RD_IM  = 8'h03;
  localparam logic [7:0] c_OP_WR_DM  = 8'h04;
  localparam logic [7:0] c_OP_WR_IM  = 8'h05;
  localparam logic [7:0] c_OP_STEP   = 8'h06;
  localparam logic [7:0] c_OP_RESUME = 8'h07;
  localparam logic [7:0] c_OP_HALT   = 8'h08;
  localparam logic [7:0] c_RESP_OK   = 8'hA5;
  localparam logic [7:0] c_RESP_ERR  = 8'hEE;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_GET_ADDR = 3'd1,
    S_GET_DATA = 3'd2,
    S_EXEC     = 3'd3,
    S_SETTLE   = 3'd4,
    S_SEND     = 3'd5,
    S_ACK      = 3'd6
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [7:0]  r_op, w_op_nxt;
  logic [7:0]  r_addr, w_addr_nxt;
  logic [31:0] r_data, w_data_nxt;
  logic [1:0]  r_cnt, w_cnt_nxt;
  logic [31:0] r_shift, w_shift_nxt;
  logic [7:0]  r_resp, w_resp_nxt;
  logic        r_debug, w_debug_nxt;
  logic        w_is_write;
`ifdef DBG_RX_TIMEOUT_EN
  logic [15:0] r_tmo, w_tmo_nxt;
`endif

  assign w_is_write = (r_op == c_OP_WR_DM) || (r_op == c_OP_WR_IM);
  assign addr       = {24'h0, r_addr};
  assign debug      = r_debug;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_op    <= '0;
      r_addr  <= '0;
      r_data  <= '0;
      r_cnt   <= '0;
      r_shift <= '0;
      r_resp  <= '0;
      r_debug <= 1'b1;
`ifdef DBG_RX_TIMEOUT_EN
      r_tmo   <= '0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_op    <= w_op_nxt;
      r_addr  <= w_addr_nxt;
      r_data  <= w_data_nxt;
      r_cnt   <= w_cnt_nxt;
      r_shift <= w_shift_nxt;
      r_resp  <= w_resp_nxt;
      r_debug <= w_debug_nxt;
`ifdef DBG_RX_TIMEOUT_EN
      r_tmo   <= w_tmo_nxt;
`endif
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_op_nxt    = r_op;
    w_addr_nxt  = r_addr;
    w_data_nxt  = r_data;
    w_cnt_nxt   = r_cnt;
    w_shift_nxt = r_shift;
    w_resp_nxt  = r_resp;
    w_debug_nxt = r_debug;
    rx_ready    = 1'b0;
    tx_valid    = 1'b0;
    tx_data     = 8'h00;
    clk_cpu     = 1'b0;
    din         = 32'h0;
    we_dm       = 1'b0;
    we_im       = 1'b0;
    clk_ld      = 1'b0;

    case (r_state)
      S_IDLE: begin
        rx_ready = 1'b1;
        if (rx_valid) begin
          w_op_nxt = rx_data;
          if (rx_data >= c_OP_RD_RF && rx_data <= c_OP_WR_IM) begin
            w_state_nxt = S_GET_ADDR;
          end else if (rx_data >= c_OP_STEP && rx_data <= c_OP_HALT) begin
            w_state_nxt = S_EXEC;
          end else begin
            w_resp_nxt  = c_RESP_ERR;
            w_state_nxt = S_ACK;
          end
        end
      end

      S_GET_ADDR: begin
        rx_ready = 1'b1;
        if (rx_valid) begin
          w_addr_nxt = rx_data;
          w_cnt_nxt  = 2'd0;
          if (w_is_write) begin
            w_state_nxt = S_GET_DATA;
          end else if (r_debug) begin
            w_state_nxt = S_SETTLE;
          end else begin
            w_resp_nxt  = c_RESP_ERR;
            w_state_nxt = S_ACK;
          end
        end
      end

      S_GET_DATA: begin
        rx_ready = 1'b1;
        if (rx_valid) begin
          // Little-endian: earlier bytes migrate toward bit 0
          w_data_nxt = {rx_data, r_data[31:8]};
          w_cnt_nxt  = r_cnt + 2'd1;
          if (r_cnt == 2'd3) begin
            w_state_nxt = S_EXEC;
          end
        end
      end

      S_EXEC: begin
        w_state_nxt = S_ACK;
        w_resp_nxt  = c_RESP_OK;
        case (r_op)
          c_OP_WR_DM, c_OP_WR_IM: begin
            if (r_debug) begin
              din    = r_data;
              we_dm  = (r_op == c_OP_WR_DM);
              we_im  = (r_op == c_OP_WR_IM);
              clk_ld = 1'b1;
            end else begin
              w_resp_nxt = c_RESP_ERR;
            end
          end
          c_OP_STEP: begin
            if (r_debug) begin
              clk_cpu     = 1'b1;
              w_state_nxt = S_SETTLE;
            end else begin
              w_resp_nxt = c_RESP_ERR;
            end
          end
          c_OP_RESUME: w_debug_nxt = 1'b0;
          c_OP_HALT:   w_debug_nxt = 1'b1;
          default:     w_resp_nxt  = c_RESP_ERR;
        endcase
      end

      S_SETTLE: begin
        case (r_op)
          c_OP_RD_RF: w_shift_nxt = dout_rf;
          c_OP_RD_DM: w_shift_nxt = dout_dm;
          c_OP_RD_IM: w_shift_nxt = dout_im;
          default:    w_shift_nxt = pc;
        endcase
        w_cnt_nxt   = 2'd0;
        w_state_nxt = S_SEND;
      end

      S_SEND: begin
        tx_valid = 1'b1;
        tx_data  = r_shift[7:0];
        if (tx_ready) begin
          w_shift_nxt = {8'h00, r_shift[31:8]};
          w_cnt_nxt   = r_cnt + 2'd1;
          if (r_cnt == 2'd3) begin
            w_state_nxt = S_IDLE;
          end
        end
      end

      S_ACK: begin
        tx_valid = 1'b1;
        tx_data  = r_resp;
        if (tx_ready) begin
          w_state_nxt = S_IDLE;
        end
      end

      default: w_state_nxt = S_IDLE;
    endcase

`ifdef DBG_RX_TIMEOUT_EN
    // Abort a stalled payload; the partially received command never executes
    w_tmo_nxt = 16'h0;
    if ((r_state == S_GET_ADDR || r_state == S_GET_DATA) && !rx_valid) begin
      if (r_tmo == 16'hFFFF) begin
        w_resp_nxt  = c_RESP_ERR;
        w_cnt_nxt   = 2'd0;
        w_state_nxt = S_ACK;
      end else begin
        w_tmo_nxt = r_tmo + 16'd1;
      end
    end
`endif
  end

endmodule
`default_nettype wire
